// File: rtl/tiny_dnn_pkg.sv
// Shared constants, frame-position struct and FSM encoding for the ReLU/max-pool stage.
// Data values are carried as real, matching the upstream convolution core array.
package tiny_dnn_pkg;

    localparam int F_NUM     = 16;
    localparam int MAX_W     = 32;
    localparam int AW        = 13;
    localparam int C_W       = $clog2(F_NUM);
    localparam int X_W       = $clog2(MAX_W);
    localparam int Y_W       = X_W;
    localparam int OS_W      = 10;
    localparam int BUF_DEPTH = F_NUM * MAX_W / 2;
    localparam int BUF_AW    = $clog2(BUF_DEPTH);

    typedef struct packed {
        logic [C_W-1:0] c;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pos_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // Ties keep the stored operand.
    function automatic real rmax(input real stored, input real v);
        return (v > stored) ? v : stored;
    endfunction

endpackage

// File: rtl/tiny_dnn_relu_pool_if.sv
// Input stream, frame configuration and output write-strobe bundle for tiny_dnn_relu_pool.
// master drives the stream/config and observes the strobes; slave is the pool block.
interface tiny_dnn_relu_pool_if;

    logic                         start;
    logic                         in_valid;
    real                          in_d;
    logic [tiny_dnn_pkg::C_W-1:0] od;
    logic [tiny_dnn_pkg::X_W-1:0] ow;
    logic [tiny_dnn_pkg::Y_W-1:0] oh;
    logic [tiny_dnn_pkg::OS_W-1:0] os;
    logic                         relu_en;
    logic                         pool_en;

    logic                         out_valid;
    logic [tiny_dnn_pkg::AW-1:0]  out_a;
    real                          out_d;
    logic                         done;

    modport master (
        output start, in_valid, in_d, od, ow, oh, os, relu_en, pool_en,
        input  out_valid, out_a, out_d, done
    );

    modport slave (
        input  start, in_valid, in_d, od, ow, oh, os, relu_en, pool_en,
        output out_valid, out_a, out_d, done
    );

endinterface

// File: rtl/tiny_dnn_pool_buf.sv
// Pool running-max buffer: 1R1W real RAM, asynchronous read, write committed at the clock edge.
// A write presented in the same cycle as a read of the same entry is forwarded to the read port.
module tiny_dnn_pool_buf
    import tiny_dnn_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [BUF_AW-1:0] wr_adr_i,
    input  real               wr_dat_i,
    input  logic [BUF_AW-1:0] rd_adr_i,
    output real               rd_dat_o
);

    real mem_q [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_adr_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = (wr_en_i && (wr_adr_i == rd_adr_i)) ? wr_dat_i : mem_q[rd_adr_i];

endmodule

// File: rtl/tiny_dnn_relu_pool.sv
// ReLU + optional 2x2/stride-2 max-pool over a serialized (y, x, c-fastest) filter-sum stream.
// Write strobe one cycle after the input; done one cycle after the last strobe. No backpressure.
module tiny_dnn_relu_pool
    import tiny_dnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    tiny_dnn_relu_pool_if.slave  bus
);

    state_t            state_q, state_d;
    pos_t              pos_q, pos_d;

    logic              acc;
    logic              last;
    logic              emit;
    logic [X_W:0]      nw;
    logic [X_W:0]      pw;
    logic [BUF_AW-1:0] rd_adr;
    real               v;
    real               b_rd;
    real               mx;
    logic [AW-1:0]     a_flat;
    logic [AW-1:0]     a_pool;

    logic              wr_en_d;
    real               wr_dat_d;
    logic              out_vld_d;
    logic [AW-1:0]     out_a_d;
    real               out_d_d;
    logic              done_d;
    logic              done_dly_d;

    logic              wr_vld_q;
    logic [BUF_AW-1:0] wr_adr_q;
    real               wr_dat_q;
    logic              out_vld_q;
    logic [AW-1:0]     out_a_q;
    real               out_d_q;
    logic              done_q;
    logic              done_dly_q;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        acc     = (state_q == ST_RUN) && bus.in_valid && !bus.start;
        last    = (pos_q.c == bus.od) && (pos_q.x == bus.ow) && (pos_q.y == bus.oh);

        if (bus.start) begin
            state_d = ST_RUN;
            pos_d   = '0;
        end else if (acc) begin
            if (pos_q.c != bus.od) begin
                pos_d.c = pos_q.c + C_W'(1);
            end else begin
                pos_d.c = '0;
                if (pos_q.x != bus.ow) begin
                    pos_d.x = pos_q.x + X_W'(1);
                end else begin
                    pos_d.x = '0;
                    pos_d.y = pos_q.y + Y_W'(1);
                end
            end
            if (last) begin
                state_d = ST_IDLE;
                pos_d   = '0;
            end
        end
    end

    // Buffer entry is per channel and per column pair; rows of a window share it.
    always_comb begin
        v      = (bus.relu_en && (bus.in_d < 0.0)) ? 0.0 : bus.in_d;
        rd_adr = {pos_q.c, pos_q.x[X_W-1:1]};
        mx     = rmax(b_rd, v);
        emit   = pos_q.x[0] & pos_q.y[0];
        nw     = {1'b0, bus.ow} + (X_W+1)'(1);
        pw     = nw >> 1;

        a_flat = AW'(pos_q.c) * AW'(bus.os) + AW'(pos_q.y) * AW'(nw) + AW'(pos_q.x);
        a_pool = AW'(pos_q.c) * AW'(bus.os) + AW'(pos_q.y[Y_W-1:1]) * AW'(pw)
               + AW'(pos_q.x[X_W-1:1]);

        wr_en_d    = acc & bus.pool_en & ~emit;
        wr_dat_d   = (!pos_q.x[0] && !pos_q.y[0]) ? v : mx;
        out_vld_d  = acc & (~bus.pool_en | emit);
        out_a_d    = bus.pool_en ? a_pool : a_flat;
        out_d_d    = bus.pool_en ? mx : v;
        done_dly_d = acc & last & out_vld_d;
        done_d     = done_dly_q | (acc & last & ~out_vld_d);
    end

    // Writes land one cycle late; the buffer forwards them to the next read.
    tiny_dnn_pool_buf u_buf (
        .clk      (clk),
        .wr_en_i  (wr_vld_q),
        .wr_adr_i (wr_adr_q),
        .wr_dat_i (wr_dat_q),
        .rd_adr_i (rd_adr),
        .rd_dat_o (b_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pos_q      <= '0;
            wr_vld_q   <= 1'b0;
            wr_adr_q   <= '0;
            wr_dat_q   <= 0.0;
            out_vld_q  <= 1'b0;
            out_a_q    <= '0;
            out_d_q    <= 0.0;
            done_q     <= 1'b0;
            done_dly_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            wr_vld_q   <= wr_en_d;
            wr_adr_q   <= rd_adr;
            wr_dat_q   <= wr_dat_d;
            out_vld_q  <= out_vld_d;
            done_q     <= done_d;
            done_dly_q <= done_dly_d;
            if (out_vld_d) begin
                out_a_q <= out_a_d;
                out_d_q <= out_d_d;
            end
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_d     = out_d_q;
    assign bus.done      = done_q;

endmodule
